// File: rtl/y86_pkg.sv
// y86_pkg: shared register-file constants, sequencer states and op encodings
package y86_pkg;
  localparam logic [3:0] RNONE = 4'hF;
  localparam int NREGS = 15;
  typedef logic [3:0] reg_idx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} seq_state_t;
  typedef enum logic [1:0] {OP_RDA, OP_RDB, OP_WRE, OP_WRM} op_t;
endpackage

// File: rtl/rf_op_pick.sv
// rf_op_pick: picks the highest-priority pending op (A > B > E > M) and clears its bit
module rf_op_pick
  import y86_pkg::*;
(
  input  logic [3:0] mask,
  output logic       valid,
  output op_t        op,
  output logic [3:0] mask_clr
);
  assign valid = |mask;
  assign op = mask[0] ? OP_RDA : mask[1] ? OP_RDB : mask[2] ? OP_WRE : OP_WRM;
  assign mask_clr = mask & (mask - 4'd1);
endmodule

// File: rtl/rf_access_seq.sv
// rf_access_seq: serialises one Y86 transaction into reads then writes on a single-port register file
module rf_access_seq
  import y86_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_srcA,
  input  logic [AW-1:0] req_srcB,
  input  logic [AW-1:0] req_dstE,
  input  logic [AW-1:0] req_dstM,
  input  logic [DW-1:0] req_valE,
  input  logic [DW-1:0] req_valM,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_valA,
  output logic [DW-1:0] resp_valB,
  output logic          rf_en,
  output logic          rf_we,
  output logic [AW-1:0] rf_idx,
  output logic [DW-1:0] rf_wval,
  input  logic [DW-1:0] rf_rdata
);
  localparam logic [AW-1:0] NONE = AW'(RNONE);
  seq_state_t st, st_n;
  logic [AW-1:0] src_a, src_b, dst_e, dst_m, cur_a, cur_b, cur_e, cur_m, idx_n;
  logic [DW-1:0] val_e, val_m, cur_ve, cur_vm, wval_n;
  logic [3:0] mask, mask_n, fresh, pick_in, pick_clr;
  logic pick_vld, idle, accept, issue, we_n, rdb_n, rd_b, cap_pend, cap_b;
  op_t pick_op;
  assign idle = st == IDLE;
  assign accept = idle && req_valid;
  assign req_ready = rst_n && idle;
  assign resp_valid = st == RESP && !cap_pend;
  // the first op is registered on the accept edge, so IDLE picks straight from the request
  assign cur_a = idle ? req_srcA : src_a;
  assign cur_b = idle ? req_srcB : src_b;
  assign cur_e = idle ? req_dstE : dst_e;
  assign cur_m = idle ? req_dstM : dst_m;
  assign cur_ve = idle ? req_valE : val_e;
  assign cur_vm = idle ? req_valM : val_m;
  assign fresh = {req_dstM != NONE, req_dstE != NONE, req_srcB != NONE, req_srcA != NONE};
  assign pick_in = idle ? fresh : mask;
  rf_op_pick u_pick (
    .mask(pick_in),
    .valid(pick_vld),
    .op(pick_op),
    .mask_clr(pick_clr)
  );
  always_comb begin
    issue = (accept || st == ISSUE) && pick_vld;
    we_n = issue && (pick_op == OP_WRE || pick_op == OP_WRM);
    rdb_n = issue && pick_op == OP_RDB;
    idx_n = !issue ? '0 : pick_op == OP_RDA ? cur_a : pick_op == OP_RDB ? cur_b :
            pick_op == OP_WRE ? cur_e : cur_m;
    wval_n = !issue ? '0 : pick_op == OP_WRE ? cur_ve : pick_op == OP_WRM ? cur_vm : '0;
    mask_n = issue ? pick_clr : mask;
    st_n = accept ? (|fresh ? ISSUE : RESP) :
           (st == ISSUE && mask == '0) ? RESP :
           (resp_valid && resp_ready) ? IDLE : st;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      mask <= '0;
      {src_a, src_b, dst_e, dst_m} <= '0;
      {val_e, val_m} <= '0;
      {rf_en, rf_we, rd_b, cap_pend, cap_b} <= '0;
      rf_idx <= '0;
      rf_wval <= '0;
      resp_valA <= '0;
      resp_valB <= '0;
    end else begin
      st <= st_n;
      mask <= mask_n;
      rf_en <= issue;
      rf_we <= we_n;
      rf_idx <= idx_n;
      rf_wval <= wval_n;
      rd_b <= rdb_n;
      cap_pend <= rf_en && !rf_we;
      cap_b <= rd_b;
      if (accept) begin
        {src_a, src_b, dst_e, dst_m} <= {req_srcA, req_srcB, req_dstE, req_dstM};
        {val_e, val_m} <= {req_valE, req_valM};
        resp_valA <= '0;
        resp_valB <= '0;
      end else if (cap_pend) begin
        if (cap_b) resp_valB <= rf_rdata;
        else resp_valA <= rf_rdata;
      end
    end
  end
  a_idx_legal: assert property (@(posedge clk) disable iff (!rst_n) rf_en |-> int'(rf_idx) < NREGS);
endmodule

// File: doc/rf_access_seq.md
# rf_access_seq

Initiator-side sequencer for the single-port Y86 register file. It accepts one transaction from the decode/writeback logic and issues up to four register-file operations, one per cycle, in the fixed order read srcA, read srcB, write dstE, write dstM. It returns the two read values to the requester. It sits between the SEQ stage logic and the register file, which serves exactly one read or write per cycle.

## Interface
Parameters:
- DW, 64, data width of register values
- AW, 4, register index width; index 4'hF is RNONE and is never issued

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  transaction offered
- req_ready  out  1  sequencer idle, can accept
- req_srcA, req_srcB  in  AW  read indices; RNONE skips the read
- req_dstE, req_dstM  in  AW  write indices; RNONE skips the write
- req_valE, req_valM  in  DW  write data for dstE and dstM
- resp_valid  out  1  valA/valB valid
- resp_ready  in  1  requester accepts response
- resp_valA, resp_valB  out  DW  read results; 0 when the read was skipped
- rf_en  out  1  register-file operation this cycle
- rf_we  out  1  1 = write, 0 = read (the register-file flag)
- rf_idx  out  AW  register index, 0..14 only
- rf_wval  out  DW  write data
- rf_rdata  in  DW  read data, valid the cycle after a read is issued

## Operation
- States: IDLE, ISSUE, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch all request fields.
  - Build a 4-bit pending mask {M,E,B,A}; a bit is set when its index is not RNONE.
  - Clear valA/valB to 0.
  - Go to ISSUE if the mask is nonzero, else RESP.
- **ISSUE**
  - Each cycle, issue the lowest pending op in priority A > B > E > M, then clear its bit.
  - No bubble cycles between ops.
  - When the last bit clears, go to RESP on the next edge.
- **Read capture**
  - A read sets cap_pend and cap_sel (A or B).
  - The next cycle, rf_rdata is written into valA/valB and cap_pend clears.
- **RESP**
  - resp_valid = (state==RESP) && !cap_pend.
  - Response data holds while resp_valid && !resp_ready.
  - On handshake, go to IDLE.
- **Ordering rules**
  - Reads precede writes, so reads always return pre-transaction register values, including when srcA==dstE.
  - dstE==dstM: both writes are issued; M is issued last and wins.
  - srcA==srcB: both reads are issued.
- **rf_idx legality:** rf_idx==4'hF with rf_en=1 is illegal. Assert it never occurs.

## Timing
- Reset values (all outputs): req_ready=0 while rst_n low, then 1 in IDLE.
  - resp_valid=0, resp_valA/B=0.
  - rf_en=0, rf_we=0, rf_idx=0, rf_wval=0.
- The rf_* outputs are registered from state and are 0 when rf_en=0.
- Let N be the number of non-RNONE fields and the accept edge be the end of cycle 0.
  - Ops are issued in cycles 1..N.
  - resp_valid is first high in cycle N+1.
  - Exception: if the last op is a read (N≥1, no writes), resp_valid is first high in cycle N+2.
  - N=0: resp_valid is high in cycle 1.
- After the response handshake edge, req_ready=1 in the next cycle; there is one transaction in flight at most.
- Reset asserted mid-transaction:
  - Immediately return to IDLE and clear the mask, cap_pend and the response registers.
  - Writes already issued stay in the register file; there is no rollback.
  - Unissued ops are dropped.
- req_* fields are sampled only on the accept edge; later changes are ignored.

## Structure
- Shared package y86_pkg:
  - RNONE = 4'hF
  - NREGS = 15
  - reg_idx_t (AW-bit)
  - the sequencer state enum
  - op encoding OP_RDA/OP_RDB/OP_WRE/OP_WRM
- One natural sub-module: rf_op_pick, a combinational priority picker from pending mask to op select plus cleared mask.

## Test plan
Bench register-file model: registered read, reg i initialised to i.
- **Full transaction:** srcA=3, srcB=5, dstE=3/valE=100, dstM=7/valM=200.
  - Ops are issued in cycles 1–4 in order A, B, E, M.
  - Response: valA=3, valB=5, resp_valid in cycle 5.
  - Afterwards reg3=100, reg7=200.
- **All RNONE:** no rf_en pulses; resp_valid in cycle 1 with valA=valB=0.
- **Reads only:** srcA=2, srcB=14, dst=RNONE.
  - resp_valid in cycle 4 (capture bubble).
  - valA=2, valB=14.
  - Hold resp_ready=0 for 3 cycles: values stable, req_ready=0.
- **Same destination:** dstE=dstM=9, valE=11, valM=22.
  - Two writes issued, E then M.
  - reg9=22.
- **Reset mid-transaction:** rst_n low in cycle 2 of the full transaction.
  - Outputs go to 0 asynchronously.
  - Writes were never issued, so reg3=3 and reg7=7.
  - req_ready=1 after release.
- **Back-to-back transactions with RNONE mixing:** run 200 random transactions.
  - rf_idx is never 15.
  - Read results match a scoreboard model.
